gate_arbiter: RTL

Round-robin controller that time-shares one registered logic-gate datapath (NOT/AND/OR/XOR on W-bit operands) among N_REQ requesters. It arbitrates requests, latches the winner's opcode and operands, sequences the gate unit through a 3-state FSM, and returns the result with a one-cycle grant/valid pulse tagged with the requester index. It sits between the board-level requesters (switch/button front-ends, test sequencers) and the shared gate datapath.

---
 rtl/gate_pkg.sv | 19 +
 rtl/gate_unit.sv | 26 ++
 rtl/gate_arbiter.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/gate_pkg.sv
// Shared definitions for the gate arbiter: opcode encodings and FSM states.
package gate_pkg;

  // Opcode encodings carried on each requester's 2-bit op field.
  localparam logic [1:0] OP_NOT = 2'b00;
  localparam logic [1:0] OP_AND = 2'b01;
  localparam logic [1:0] OP_OR  = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;

  typedef logic [1:0] opcode_t;

  // Arbiter sequencing: sample and latch, evaluate, present result.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/gate_unit.sv
// Purely combinational W-bit logic gate selected by a 2-bit opcode.
// The result register lives in the arbiter; this block has no state.
module gate_unit
  import gate_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [1:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);

  // Select the bitwise operation; NOT ignores operand b entirely.
  always_comb begin
    y = '0;
    case (op)
      OP_NOT:  y = ~a;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/gate_arbiter.sv
// Round-robin controller sharing one registered gate datapath among N_REQ
// requesters. A winner is picked in IDLE, its operands are latched, the gate
// result is registered during EXEC and presented with a one-cycle grant and
// valid strobe in RESP.
module gate_arbiter
  import gate_pkg::*;
#(
  parameter  int N_REQ = 4,
  parameter  int W     = 8,
  localparam int IDW   = $clog2(N_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req,
  input  logic [2*N_REQ-1:0]   op,
  input  logic [W*N_REQ-1:0]   a_in,
  input  logic [W*N_REQ-1:0]   b_in,
  output logic [N_REQ-1:0]     grant,
  output logic [W-1:0]         res,
  output logic                 res_valid,
  output logic [IDW-1:0]       res_id,
  output logic                 busy
);

  state_t         state;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] id_q;
  logic [1:0]     op_q;
  logic [W-1:0]   a_q;
  logic [W-1:0]   b_q;

  logic [IDW-1:0] win_id;
  logic           any_req;
  logic [1:0]     win_op;
  logic [W-1:0]   win_a;
  logic [W-1:0]   win_b;
  logic [W-1:0]   gate_y;

  // Walk the request vector starting at ptr and wrapping; first set bit wins.
  // When no bit is set the returned index is don't-care (any_req gates it).
  function automatic logic [IDW-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                             input logic [IDW-1:0]   p);
    logic [IDW-1:0] win;
    logic           found;
    int             idx;
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(p) + k) % N_REQ;
      if (!found && r[idx]) begin
        found = 1'b1;
        win   = IDW'(idx);
      end
    end
    return win;
  endfunction

  // Pointer advance with explicit wrap so non-power-of-two N_REQ works.
  function automatic logic [IDW-1:0] next_ptr(input logic [IDW-1:0] id);
    if (id == IDW'(N_REQ - 1)) begin
      return '0;
    end
    return id + IDW'(1);
  endfunction

  // One-hot grant vector for a requester index.
  function automatic logic [N_REQ-1:0] onehot(input logic [IDW-1:0] id);
    return N_REQ'(1) << id;
  endfunction

  // Pick the winner and slice out its opcode and operands from the packed buses.
  always_comb begin
    int sel;
    win_id  = rr_pick(req, ptr);
    any_req = |req;
    sel     = int'(win_id);
    win_op  = op[2*sel +: 2];
    win_a   = a_in[W*sel +: W];
    win_b   = b_in[W*sel +: W];
  end

  gate_unit #(
    .W (W)
  ) u_gate (
    .op (op_q),
    .a  (a_q),
    .b  (b_q),
    .y  (gate_y)
  );

  // Main FSM: all outputs are registered here; grant and res_valid default
  // low each cycle so they only pulse during RESP, while res and res_id hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      id_q      <= '0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      grant     <= '0;
      res       <= '0;
      res_valid <= 1'b0;
      res_id    <= '0;
      busy      <= 1'b0;
    end else begin
      grant     <= '0;
      res_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            id_q  <= win_id;
            op_q  <= win_op;
            a_q   <= win_a;
            b_q   <= win_b;
            busy  <= 1'b1;
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          res       <= gate_y;
          res_id    <= id_q;
          grant     <= onehot(id_q);
          res_valid <= 1'b1;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          ptr   <= next_ptr(id_q);
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
